counter_prop_monitor: RTL

//  Synthesisable, multi-channel property monitor for loadable counters with carry.

---
 rtl/counter_mon_pkg.sv | 40 ++++
 rtl/counter_mon_ch.sv | 126 ++++++++++++
 rtl/counter_prop_monitor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/counter_mon_pkg.sv
// -----------------------------------------------------------------------------
// counter_mon_pkg
// Shared types and helpers for the counter property monitor.
//   chk_e       : check identifiers, also the encoding of first_err_chk
//   carry_st_e  : states of the per-channel carry pulse-width FSM
//   sat_add     : saturating add used by the statistics counters
// Optional build macro used by the monitor: COUNTER_MON_STRICT_EN
// -----------------------------------------------------------------------------
package counter_mon_pkg;

    // Working width of sat_add; statistics counters must not be wider.
    localparam int SAT_W = 32;

    typedef enum logic [1:0] {
        CHK_CARRY   = 2'd0,
        CHK_ADVANCE = 2'd1,
        CHK_LOAD    = 2'd2
    } chk_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } carry_st_e;

    // Returns a + b clipped to max_val. The sum carries one extra bit so an
    // overflow of the working width is also clipped correctly.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic [SAT_W-1:0] max_val
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/counter_mon_ch.sv
// -----------------------------------------------------------------------------
// counter_mon_ch
// One monitored channel: history registers, carry pulse-width FSM and the
// advance/load arm pipeline. Results are produced combinationally in the
// evaluation cycle and accumulated by the top level on the same clock edge.
//   clk, resetn   : clock / asynchronous active-low reset
//   enable        : count enable of the observed counter
//   wenable       : load enable of the observed counter
//   wcount        : load value of the observed counter
//   count, carry  : observed counter value and carry
//   pass_vec[0]   : carry check passed this cycle
//   pass_vec[1]   : advance or load check passed this cycle
//   fail_vec[1:0] : same slots, failures
//   ld_sel        : slot 1 currently carries a LOAD result (else ADVANCE)
// Build macro COUNTER_MON_STRICT_EN: advance must be exactly +1 (mod 2^P_BIT).
// -----------------------------------------------------------------------------
module counter_mon_ch
    import counter_mon_pkg::*;
#(
    parameter int P_BIT       = 4,
    parameter int P_CARRY_MAX = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             wenable,
    input  logic [P_BIT-1:0] wcount,
    input  logic [P_BIT-1:0] count,
    input  logic             carry,
    output logic [1:0]       pass_vec,
    output logic [1:0]       fail_vec,
    output logic             ld_sel
);

    localparam int K_W = $clog2(P_CARRY_MAX + 1);

    logic             hist_vld_q, hist_vld_d;
    logic [P_BIT-1:0] count_q, count_d;
    logic [P_BIT-1:0] wcount_q, wcount_d;
    logic             carry_q, carry_d;
    carry_st_e        st_q, st_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             adv_arm_q, adv_arm_d;
    logic             ld_arm_q, ld_arm_d;

    logic carry_pass, carry_fail;
    logic adv_ok, ld_ok;

    always_comb begin
        // History follows the inputs every cycle; hist_vld marks that the
        // history holds at least one real post-reset sample.
        hist_vld_d = 1'b1;
        count_d    = count;
        wcount_d   = wcount;
        carry_d    = carry;

        // Load has priority over enable, so the two arms are exclusive.
        adv_arm_d  = hist_vld_q & enable & ~wenable;
        ld_arm_d   = hist_vld_q & wenable;

        st_d       = st_q;
        k_d        = k_q;
        carry_pass = 1'b0;
        carry_fail = 1'b0;

        case (st_q)
            ST_IDLE: begin
                // A rise requires carry_q = 0, so attempts never overlap.
                if (hist_vld_q && carry && !carry_q) begin
                    st_d = ST_WAIT;
                    k_d  = K_W'(1);
                end
            end
            ST_WAIT: begin
                if (hist_vld_q) begin
                    if (!carry) begin
                        carry_pass = 1'b1;
                        st_d       = ST_IDLE;
                    end else if (k_q == K_W'(P_CARRY_MAX)) begin
                        carry_fail = 1'b1;
                        st_d       = ST_IDLE;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase

`ifdef COUNTER_MON_STRICT_EN
        adv_ok = (count == count_q + P_BIT'(1));
`else
        adv_ok = (count != count_q);
`endif
        ld_ok = (count == wcount_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_vld_q <= 1'b0;
            count_q    <= '0;
            wcount_q   <= '0;
            carry_q    <= 1'b0;
            st_q       <= ST_IDLE;
            k_q        <= '0;
            adv_arm_q  <= 1'b0;
            ld_arm_q   <= 1'b0;
        end else begin
            hist_vld_q <= hist_vld_d;
            count_q    <= count_d;
            wcount_q   <= wcount_d;
            carry_q    <= carry_d;
            st_q       <= st_d;
            k_q        <= k_d;
            adv_arm_q  <= adv_arm_d;
            ld_arm_q   <= ld_arm_d;
        end
    end

    assign pass_vec[0] = carry_pass;
    assign fail_vec[0] = carry_fail;
    assign pass_vec[1] = (adv_arm_q & adv_ok) | (ld_arm_q & ld_ok);
    assign fail_vec[1] = (adv_arm_q & ~adv_ok) | (ld_arm_q & ~ld_ok);
    assign ld_sel      = ld_arm_q;

endmodule

// File: rtl/counter_prop_monitor.sv
// -----------------------------------------------------------------------------
// counter_prop_monitor
// Multi-channel property monitor for loadable counters with carry. Each
// channel checks carry pulse width, count advance and count load; the top
// accumulates saturating pass/fail/fire statistics, per-channel sticky error
// flags and a capture of the first failure.
//   clk, resetn          : clock / asynchronous active-low reset
//   enable, wenable      : per-channel count / load enables
//   wcount, count        : per-channel load value / counter value (ch i at
//                          [i*P_BIT +: P_BIT])
//   carry                : per-channel carry
//   clr_stats            : synchronous clear of statistics, sticky flags and
//                          first-error capture (FSMs and arms untouched)
//   pass_cnt, fail_cnt   : saturating counts of passed / failed checks
//   fire_cnt             : saturating count of evaluated checks
//   err_sticky           : channel has failed since reset / clear
//   first_err_vld/ch/chk : first captured failure (chk encoded as chk_e)
// Build macro COUNTER_MON_STRICT_EN: advance must be exactly +1 (mod 2^P_BIT).
// -----------------------------------------------------------------------------
module counter_prop_monitor
    import counter_mon_pkg::*;
#(
    parameter int P_BIT       = 4,
    parameter int P_CH        = 2,
    parameter int P_CARRY_MAX = 3,
    parameter int P_CNT_W     = 16,
    localparam int CH_W       = (P_CH > 1) ? $clog2(P_CH) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [P_CH-1:0]       enable,
    input  logic [P_CH-1:0]       wenable,
    input  logic [P_CH*P_BIT-1:0] wcount,
    input  logic [P_CH*P_BIT-1:0] count,
    input  logic [P_CH-1:0]       carry,
    input  logic                  clr_stats,
    output logic [P_CNT_W-1:0]    pass_cnt,
    output logic [P_CNT_W-1:0]    fail_cnt,
    output logic [P_CNT_W-1:0]    fire_cnt,
    output logic [P_CH-1:0]       err_sticky,
    output logic                  first_err_vld,
    output logic [CH_W-1:0]       first_err_ch,
    output logic [1:0]            first_err_chk
);

    localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

    logic [2*P_CH-1:0] pass_all;
    logic [2*P_CH-1:0] fail_all;
    logic [P_CH-1:0]   ld_sel_all;

    for (genvar gi = 0; gi < P_CH; gi++) begin : g_ch
        counter_mon_ch #(
            .P_BIT       (P_BIT),
            .P_CARRY_MAX (P_CARRY_MAX)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .enable   (enable[gi]),
            .wenable  (wenable[gi]),
            .wcount   (wcount[gi*P_BIT +: P_BIT]),
            .count    (count[gi*P_BIT +: P_BIT]),
            .carry    (carry[gi]),
            .pass_vec (pass_all[2*gi +: 2]),
            .fail_vec (fail_all[2*gi +: 2]),
            .ld_sel   (ld_sel_all[gi])
        );
    end

    logic [P_CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [P_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [P_CNT_W-1:0] fire_cnt_q, fire_cnt_d;
    logic [P_CH-1:0]    err_sticky_q, err_sticky_d;
    logic               first_err_vld_q, first_err_vld_d;
    logic [CH_W-1:0]    first_err_ch_q, first_err_ch_d;
    chk_e               first_err_chk_q, first_err_chk_d;

    logic [SAT_W-1:0] pass_add, fail_add, fire_add;
    logic [P_CH-1:0]  ch_fail;
    logic             found;
    logic [CH_W-1:0]  cap_ch;
    chk_e             cap_chk;

    always_comb begin
        pass_add = '0;
        fail_add = '0;
        for (int i = 0; i < 2*P_CH; i++) begin
            pass_add = pass_add + SAT_W'(pass_all[i]);
            fail_add = fail_add + SAT_W'(fail_all[i]);
        end
        // fire has its own saturating counter, so it is not derived from the
        // other two once either of them has clipped.
        fire_add = pass_add + fail_add;

        // Priority: lowest channel first, then lowest check code. Slot 0
        // (carry) always has the lowest code within a channel.
        found   = 1'b0;
        cap_ch  = '0;
        cap_chk = CHK_CARRY;
        for (int i = 0; i < P_CH; i++) begin
            ch_fail[i] = |fail_all[2*i +: 2];
            if (!found) begin
                if (fail_all[2*i]) begin
                    found   = 1'b1;
                    cap_ch  = CH_W'(i);
                    cap_chk = CHK_CARRY;
                end else if (fail_all[2*i+1]) begin
                    found   = 1'b1;
                    cap_ch  = CH_W'(i);
                    cap_chk = ld_sel_all[i] ? CHK_LOAD : CHK_ADVANCE;
                end
            end
        end

        pass_cnt_d      = pass_cnt_q;
        fail_cnt_d      = fail_cnt_q;
        fire_cnt_d      = fire_cnt_q;
        err_sticky_d    = err_sticky_q;
        first_err_vld_d = first_err_vld_q;
        first_err_ch_d  = first_err_ch_q;
        first_err_chk_d = first_err_chk_q;

        if (clr_stats) begin
            // Clear wins over any result produced in the same cycle.
            pass_cnt_d      = '0;
            fail_cnt_d      = '0;
            fire_cnt_d      = '0;
            err_sticky_d    = '0;
            first_err_vld_d = 1'b0;
            first_err_ch_d  = '0;
            first_err_chk_d = CHK_CARRY;
        end else begin
            pass_cnt_d   = P_CNT_W'(sat_add(SAT_W'(pass_cnt_q), pass_add, SAT_W'(CNT_MAX)));
            fail_cnt_d   = P_CNT_W'(sat_add(SAT_W'(fail_cnt_q), fail_add, SAT_W'(CNT_MAX)));
            fire_cnt_d   = P_CNT_W'(sat_add(SAT_W'(fire_cnt_q), fire_add, SAT_W'(CNT_MAX)));
            err_sticky_d = err_sticky_q | ch_fail;
            if (!first_err_vld_q && found) begin
                first_err_vld_d = 1'b1;
                first_err_ch_d  = cap_ch;
                first_err_chk_d = cap_chk;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pass_cnt_q      <= '0;
            fail_cnt_q      <= '0;
            fire_cnt_q      <= '0;
            err_sticky_q    <= '0;
            first_err_vld_q <= 1'b0;
            first_err_ch_q  <= '0;
            first_err_chk_q <= CHK_CARRY;
        end else begin
            pass_cnt_q      <= pass_cnt_d;
            fail_cnt_q      <= fail_cnt_d;
            fire_cnt_q      <= fire_cnt_d;
            err_sticky_q    <= err_sticky_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_ch_q  <= first_err_ch_d;
            first_err_chk_q <= first_err_chk_d;
        end
    end

    assign pass_cnt      = pass_cnt_q;
    assign fail_cnt      = fail_cnt_q;
    assign fire_cnt      = fire_cnt_q;
    assign err_sticky    = err_sticky_q;
    assign first_err_vld = first_err_vld_q;
    assign first_err_ch  = first_err_ch_q;
    assign first_err_chk = first_err_chk_q;

endmodule
